// File: rtl/lsa_mem_pkg.sv
// Shared constants for the LSA memory/peripheral block: I/O window offsets
// and the value returned for unmapped reads.
package lsa_mem_pkg;

    typedef enum logic [2:0] {
        LED_OFS     = 3'd0,
        LED_SET_OFS = 3'd1,
        LED_CLR_OFS = 3'd2,
        LED_TGL_OFS = 3'd3,
        TIMER_OFS   = 3'd4,
        CMP_OFS     = 3'd5,
        STAT_OFS    = 3'd6,
        RSVD_OFS    = 3'd7
    } io_ofs_e;

    localparam logic [63:0] UNMAPPED_DATA = '1;

endpackage

// File: rtl/lsa_mem_timer.sv
// Prescaled compare timer: free-running prescaler, up-counter with compare
// match, sticky match flag and a one-cycle tick pulse.
module lsa_mem_timer #(
    parameter int DATA_W   = 16,
    parameter int PRESCALE = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tmr_we_i,
    input  logic              cmp_we_i,
    input  logic              flag_clr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] timer_o,
    output logic [DATA_W-1:0] cmp_o,
    output logic              flag_o,
    output logic              tick_o
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   ps_q, ps_d;
    logic [DATA_W-1:0] timer_q, timer_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic              flag_q, flag_d;
    logic              tick_q, tick_d;
    logic              wrap, match;

    assign wrap  = (ps_q == PS_W'(PRESCALE - 1));
    // A timer load on the wrap cycle takes priority and suppresses the match.
    assign match = wrap && !tmr_we_i && (timer_q == cmp_q);

    always_comb begin
        ps_d    = wrap ? '0 : ps_q + PS_W'(1);
        timer_d = timer_q;
        if (tmr_we_i) begin
            timer_d = wdata_i;
            ps_d    = '0;
        end else if (wrap) begin
            timer_d = match ? '0 : timer_q + DATA_W'(1);
        end
        cmp_d  = cmp_we_i ? wdata_i : cmp_q;
        flag_d = match ? 1'b1 : (flag_clr_i ? 1'b0 : flag_q);
        tick_d = match;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps_q    <= '0;
            timer_q <= '0;
            cmp_q   <= '0;
            flag_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            flag_q  <= flag_d;
            tick_q  <= tick_d;
        end
    end

    assign timer_o = timer_q;
    assign cmp_o   = cmp_q;
    assign flag_o  = flag_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/lsa_mem_io.sv
// LSA CPU memory block: word RAM, LED register with set/clear/toggle aliases
// and a compare timer in one I/O window; reads are registered.
module lsa_mem_io
    import lsa_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] IO_BASE   = 16'hF100,
    parameter int                NUM_LED   = 8,
    parameter int                PRESCALE  = 1000
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic               mem_fetch,
    input  logic               mem_we,
    input  logic               mem_oe,
    input  logic [ADDR_W-1:0]  mem_add,
    input  logic [DATA_W-1:0]  mem_in,
    output logic [DATA_W-1:0]  mem_out,
    output logic               mem_valid,
    output logic [NUM_LED-1:0] mem_led_out,
    output logic               mem_tick_out
);
    localparam int                RAM_AW   = $clog2(RAM_DEPTH);
    localparam logic [DATA_W-1:0] UNMAPPED = UNMAPPED_DATA[DATA_W-1:0];

    logic [DATA_W-1:0]  ram [RAM_DEPTH];
    logic [DATA_W-1:0]  mem_out_q, mem_out_d;
    logic               mem_valid_q;
    logic [NUM_LED-1:0] led_q, led_d;
    logic [ADDR_W-1:0]  io_ofs;
    io_ofs_e            ofs;
    logic               rd_en, ram_hit, io_hit;
    logic               tmr_we, cmp_we, flag_clr;
    logic [DATA_W-1:0]  timer_val, cmp_val;
    logic               flag, tick;

    assign rd_en   = mem_oe | mem_fetch;
    assign ram_hit = (mem_add < ADDR_W'(RAM_DEPTH));
    // Unsigned wrap of the subtraction makes one compare cover both window bounds.
    assign io_ofs  = mem_add - IO_BASE;
    assign io_hit  = (io_ofs < ADDR_W'(8));
    assign ofs     = io_ofs_e'(io_ofs[2:0]);

    assign tmr_we   = mem_we && io_hit && (ofs == TIMER_OFS);
    assign cmp_we   = mem_we && io_hit && (ofs == CMP_OFS);
    assign flag_clr = mem_we && io_hit && (ofs == STAT_OFS) && mem_in[0];

    lsa_mem_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i      (clock_in),
        .rst_i      (reset_in),
        .tmr_we_i   (tmr_we),
        .cmp_we_i   (cmp_we),
        .flag_clr_i (flag_clr),
        .wdata_i    (mem_in),
        .timer_o    (timer_val),
        .cmp_o      (cmp_val),
        .flag_o     (flag),
        .tick_o     (tick)
    );

    always_ff @(posedge clock_in) begin
        if (mem_we && ram_hit && !reset_in) begin
            ram[mem_add[RAM_AW-1:0]] <= mem_in;
        end
    end

    // Read mux samples pre-write state, giving read-before-write on collisions.
    always_comb begin
        mem_out_d = UNMAPPED;
        if (ram_hit) begin
            mem_out_d = ram[mem_add[RAM_AW-1:0]];
        end else if (io_hit) begin
            unique case (ofs)
                LED_OFS, LED_SET_OFS, LED_CLR_OFS, LED_TGL_OFS: begin
                    mem_out_d = '0;
                    mem_out_d[NUM_LED-1:0] = led_q;
                end
                TIMER_OFS: mem_out_d = timer_val;
                CMP_OFS:   mem_out_d = cmp_val;
                STAT_OFS: begin
                    mem_out_d = '0;
                    mem_out_d[0] = flag;
                end
                default:   mem_out_d = UNMAPPED;
            endcase
        end
    end

    always_comb begin
        led_d = led_q;
        if (mem_we && io_hit) begin
            unique case (ofs)
                LED_OFS:     led_d = mem_in[NUM_LED-1:0];
                LED_SET_OFS: led_d = led_q | mem_in[NUM_LED-1:0];
                LED_CLR_OFS: led_d = led_q & ~mem_in[NUM_LED-1:0];
                LED_TGL_OFS: led_d = led_q ^ mem_in[NUM_LED-1:0];
                default:     led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            led_q       <= '0;
            mem_out_q   <= UNMAPPED;
            mem_valid_q <= 1'b0;
        end else begin
            led_q       <= led_d;
            mem_valid_q <= rd_en;
            if (rd_en) begin
                mem_out_q <= mem_out_d;
            end
        end
    end

    assign mem_out      = mem_out_q;
    assign mem_valid    = mem_valid_q;
    assign mem_led_out  = led_q;
    assign mem_tick_out = tick;

endmodule

// File: tb/tb_lsa_mem_io.sv
// Directed bench for lsa_mem_io: RAM, LED aliases, read-before-write,
// timer match/flag/collisions and synchronous reset.
module tb_lsa_mem_io;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        mem_fetch = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_oe = 1'b0;
    logic [15:0] mem_add = '0;
    logic [15:0] mem_in = '0;
    logic [15:0] mem_out;
    logic        mem_valid;
    logic [7:0]  mem_led_out;
    logic        mem_tick_out;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;
    int r_edge, t_wr, t1, t2;

    lsa_mem_io #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .RAM_DEPTH (256),
        .IO_BASE   (16'hF100),
        .NUM_LED   (8),
        .PRESCALE  (4)
    ) dut (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .mem_fetch    (mem_fetch),
        .mem_we       (mem_we),
        .mem_oe       (mem_oe),
        .mem_add      (mem_add),
        .mem_in       (mem_in),
        .mem_out      (mem_out),
        .mem_valid    (mem_valid),
        .mem_led_out  (mem_led_out),
        .mem_tick_out (mem_tick_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic cyc();
        @(posedge clock_in);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem_add = a;
        mem_in  = d;
        mem_we  = 1'b1;
        cyc();
        mem_we  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        mem_add = a;
        mem_oe  = 1'b1;
        cyc();
        mem_oe  = 1'b0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        cyc();
        reset_in = 1'b0;
        r_edge = edge_n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_out", mem_out, 16'hFFFF);
        chk("rst_valid", mem_valid, 0);
        chk("rst_led", mem_led_out, 0);
        chk("rst_tick", mem_tick_out, 0);

        // RAM round trip and unmapped reads
        wr(16'd5, 16'h1234);
        chk("wr_no_valid", mem_valid, 0);
        rd(16'd5);
        chk("ram5_data", mem_out, 16'h1234);
        chk("ram5_valid", mem_valid, 1);
        cyc();
        chk("idle_valid", mem_valid, 0);
        chk("idle_hold", mem_out, 16'h1234);
        mem_add = 16'd5;
        mem_fetch = 1'b1;
        cyc();
        mem_fetch = 1'b0;
        chk("fetch_valid", mem_valid, 1);
        chk("fetch_data", mem_out, 16'h1234);
        rd(16'h0200);
        chk("unmapped_0200", mem_out, 16'hFFFF);
        rd(16'hF107);
        chk("unmapped_f107", mem_out, 16'hFFFF);

        // LED register and aliases
        wr(16'hF100, 16'h00F0);
        chk("led_load", mem_led_out, 8'hF0);
        wr(16'hF101, 16'h0003);
        chk("led_set", mem_led_out, 8'hF3);
        wr(16'hF102, 16'h0010);
        chk("led_clr", mem_led_out, 8'hE3);
        wr(16'hF103, 16'h0081);
        chk("led_tgl", mem_led_out, 8'h62);
        rd(16'hF100);
        chk("led_read", mem_out, 16'h0062);
        rd(16'hF101);
        chk("led_set_read", mem_out, 16'h0062);

        // Read-before-write on RAM and on a register
        wr(16'd7, 16'hAAAA);
        mem_add = 16'd7; mem_in = 16'h5555; mem_we = 1'b1; mem_oe = 1'b1;
        cyc();
        mem_we = 1'b0; mem_oe = 1'b0;
        chk("rbw_ram_old", mem_out, 16'hAAAA);
        rd(16'd7);
        chk("rbw_ram_new", mem_out, 16'h5555);
        mem_add = 16'hF100; mem_in = 16'h0011; mem_we = 1'b1; mem_oe = 1'b1;
        cyc();
        mem_we = 1'b0; mem_oe = 1'b0;
        chk("rbw_led_old", mem_out, 16'h0062);
        chk("rbw_led_new", mem_led_out, 8'h11);

        // Timer match with COMPARE=2 and PRESCALE=4: period 12 cycles
        do_reset();
        wr(16'hF105, 16'h0002);
        t_wr = edge_n;
        t1 = -1;
        for (int k = 0; k < 40 && t1 < 0; k++) begin
            cyc();
            if (mem_tick_out) t1 = edge_n;
        end
        chk("tick1_latency", t1 - t_wr, 11);
        rd(16'hF106);
        chk("tick1_one_cycle", mem_tick_out, 0);
        chk("stat_set", mem_out, 16'h0001);
        t2 = -1;
        for (int k = 0; k < 40 && t2 < 0; k++) begin
            cyc();
            if (mem_tick_out) t2 = edge_n;
        end
        chk("tick_period", t2 - t1, 12);
        wr(16'hF106, 16'h0001);
        rd(16'hF106);
        chk("stat_cleared", mem_out, 16'h0000);
        while (edge_n < t2 + 11) cyc();
        wr(16'hF106, 16'h0001);
        chk("tick3_with_clear", mem_tick_out, 1);
        rd(16'hF106);
        chk("stat_set_wins", mem_out, 16'h0001);

        // TIMER load on the wrap cycle (COMPARE=0 would otherwise match)
        do_reset();
        cyc(); cyc(); cyc();
        wr(16'hF104, 16'h0010);
        chk("load_no_tick", mem_tick_out, 0);
        rd(16'hF104);
        chk("load_timer_val", mem_out, 16'h0010);
        chk("load_no_tick2", mem_tick_out, 0);
        rd(16'hF106);
        chk("load_stat_zero", mem_out, 16'h0000);
        while (edge_n < r_edge + 8) cyc();
        rd(16'hF104);
        chk("timer_incr", mem_out, 16'h0011);

        // Synchronous reset mid-operation, overriding a RAM write
        wr(16'hF100, 16'h00FF);
        chk("led_ff", mem_led_out, 8'hFF);
        mem_add = 16'd5; mem_in = 16'hBEEF; mem_we = 1'b1; mem_oe = 1'b1;
        do_reset();
        mem_we = 1'b0; mem_oe = 1'b0;
        chk("mid_rst_led", mem_led_out, 0);
        chk("mid_rst_valid", mem_valid, 0);
        chk("mid_rst_out", mem_out, 16'hFFFF);
        chk("mid_rst_tick", mem_tick_out, 0);
        rd(16'hF104);
        chk("mid_rst_timer", mem_out, 16'h0000);
        rd(16'd5);
        chk("ram_kept", mem_out, 16'h1234);
        rd(16'hF105);
        chk("mid_rst_cmp", mem_out, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
